// File: rtl/data_unalign.sv
// rtl/data_unalign.sv - unpacks compacted sample bytes and re-expands them to 32-bit channel positions
// Optional macro DATA_UNALIGN_RESIDUAL_EN adds the sticky err_residual output.
`timescale 1ns/1ps
module data_unalign #(
   parameter int DW = 32,
   parameter int KW = DW/8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [3:0]    disabledGroups,
   input  logic          sti_valid,
   output logic          sti_ready,
   input  logic [DW-1:0] sti_data,
   output logic          sto_valid,
   input  logic          sto_ready,
   output logic [DW-1:0] sto_data
`ifdef DATA_UNALIGN_RESIDUAL_EN
   ,
   output logic          err_residual
`endif
);

   localparam int BW = 2*KW*8;

   logic [3:0]    cfg;
   logic          cfg_load;
   logic [BW-1:0] buf_q;
   logic [3:0]    fill;

   logic [3:0]    dis;
   logic [3:0]    n;
   logic          push, pop;
   logic [3:0]    base;
   logic [BW-1:0] shifted, mask, word, buf_next;
   logic [3:0]    fill_next;
   logic [2:0]    k;

   // all-disabled config means passthrough of all four groups
   assign dis = (cfg == 4'hf) ? 4'h0 : cfg;

   always_comb begin
      n = 4'd0;
      for (int g = 0; g < 4; g++)
         n = n + {3'b000, ~dis[g]};
   end

   assign sti_ready = (fill <= 4'd4);
   assign sto_valid = (fill >= n);
   assign push      = sti_valid && sti_ready;
   assign pop       = sto_valid && sto_ready;

   always_comb begin
      base      = pop ? (fill - n) : fill;
      shifted   = pop ? (buf_q >> {n, 3'b000}) : buf_q;
      mask      = {{(BW-DW){1'b0}}, {DW{1'b1}}} << {base, 3'b000};
      word      = {{(BW-DW){1'b0}}, sti_data} << {base, 3'b000};
      buf_next  = push ? ((shifted & ~mask) | word) : shifted;
      fill_next = fill + (push ? 4'd4 : 4'd0) - (pop ? n : 4'd0);
   end

   // buffer byte k lands in the k-th enabled group, ascending
   always_comb begin
      sto_data = '0;
      k        = 3'd0;
      for (int g = 0; g < 4; g++) begin
         if (!dis[g]) begin
            sto_data[8*g +: 8] = buf_q[{k, 3'b000} +: 8];
            k = k + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg      <= 4'b0000;
         cfg_load <= 1'b1;
         fill     <= 4'd0;
         buf_q    <= '0;
      end else begin
         cfg_load <= 1'b0;
         if (cfg_load || clr)
            cfg <= disabledGroups;
         if (clr) begin
            fill <= 4'd0;
         end else begin
            fill  <= fill_next;
            buf_q <= buf_next;
         end
      end
   end

`ifdef DATA_UNALIGN_RESIDUAL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_residual <= 1'b0;
      else if (clr && (fill != 4'd0) && (fill < n))
         err_residual <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_data_unalign.sv
// tb/tb_data_unalign.sv - randomized and directed check of data_unalign against a byte-queue model
`timescale 1ns/1ps
module tb_data_unalign;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic [3:0]  disabledGroups = 4'b0000;
   logic        sti_valid = 1'b0;
   logic        sti_ready;
   logic [31:0] sti_data = 32'h0;
   logic        sto_valid;
   logic        sto_ready = 1'b0;
   logic [31:0] sto_data;
`ifdef DATA_UNALIGN_RESIDUAL_EN
   logic        err_residual;
`endif

   always #5 clk = ~clk;

   data_unalign dut (
      .clk(clk), .rst(rst), .clr(clr), .disabledGroups(disabledGroups),
      .sti_valid(sti_valid), .sti_ready(sti_ready), .sti_data(sti_data),
      .sto_valid(sto_valid), .sto_ready(sto_ready), .sto_data(sto_data)
`ifdef DATA_UNALIGN_RESIDUAL_EN
      , .err_residual(err_residual)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  mq[$];
   logic [31:0] in_q[$];
   logic [31:0] out_log[$];
   logic [3:0]  cfg_m;
   bit          load_m;
   bit          err_m;
   int          max_fill;

   function automatic int nm();
      logic [3:0] d;
      int c;
      d = (cfg_m == 4'hf) ? 4'h0 : cfg_m;
      c = 0;
      for (int g = 0; g < 4; g++) if (!d[g]) c++;
      return c;
   endfunction

   function automatic logic [31:0] expand();
      logic [3:0]  d;
      logic [31:0] r;
      int k;
      d = (cfg_m == 4'hf) ? 4'h0 : cfg_m;
      r = 32'h0;
      k = 0;
      for (int g = 0; g < 4; g++) begin
         if (!d[g]) begin
            r[8*g +: 8] = mq[k];
            k++;
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // called at a falling edge: compare, drive, advance model at the rising edge
   task automatic step(input bit vin, input bit rdy, input bit c);
      bit mr, mv, push, pop;
      int n;
      n  = nm();
      mr = (mq.size() <= 4);
      mv = (mq.size() >= n);
      chk("sti_ready", {31'b0, sti_ready}, {31'b0, mr});
      chk("sto_valid", {31'b0, sto_valid}, {31'b0, mv});
      if (mv) chk("sto_data", sto_data, expand());
`ifdef DATA_UNALIGN_RESIDUAL_EN
      chk("err_residual", {31'b0, err_residual}, {31'b0, err_m});
`endif
      sti_valid = vin && (in_q.size() > 0);
      sti_data  = (in_q.size() > 0) ? in_q[0] : $urandom;
      sto_ready = rdy;
      clr       = c;
      @(posedge clk);
      push = sti_valid && mr;
      pop  = mv && rdy;
      if (push) void'(in_q.pop_front());
      if (c) begin
         if (mq.size() > 0 && mq.size() < n) err_m = 1'b1;
         mq.delete();
         cfg_m  = disabledGroups;
         load_m = 1'b0;
      end else begin
         if (pop) begin
            out_log.push_back(expand());
            repeat (n) void'(mq.pop_front());
         end
         if (push) for (int b = 0; b < 4; b++) mq.push_back(sti_data[8*b +: 8]);
         if (load_m) begin
            cfg_m  = disabledGroups;
            load_m = 1'b0;
         end
      end
      if (mq.size() > max_fill) max_fill = mq.size();
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic do_reset(input logic [3:0] dg);
      rst = 1'b1;
      disabledGroups = dg;
      sti_valid = 1'b0;
      sto_ready = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst sto_valid", {31'b0, sto_valid}, 32'd0);
      chk("rst sti_ready", {31'b0, sti_ready}, 32'd1);
      chk("rst sto_data", sto_data, 32'h0);
      mq.delete();
      in_q.delete();
      out_log.delete();
      cfg_m  = 4'b0000;
      load_m = 1'b1;
      err_m  = 1'b0;
      rst = 1'b0;
   endtask

   task automatic set_cfg(input logic [3:0] dg);
      disabledGroups = dg;
      step(0, 0, 1);
      out_log.delete();
      max_fill = 0;
   endtask

   initial begin
      max_fill = 0;
      do_reset(4'b0000);

      // straight passthrough, one word per cycle
      in_q.push_back(32'h11223344);
      in_q.push_back(32'h55667788);
      step(1, 1, 0);
      step(1, 1, 0);
      chk("pass first", out_log.size() > 0 ? out_log[0] : 32'hx, 32'h11223344);
      step(1, 1, 0);
      chk("pass count", out_log.size(), 2);
      chk("pass second", out_log.size() > 1 ? out_log[1] : 32'hx, 32'h55667788);

      // groups 0 and 2 enabled
      set_cfg(4'b1010);
      in_q.push_back(32'hDDCCBBAA);
      repeat (3) step(1, 1, 0);
      chk("g02 s0", out_log.size() > 0 ? out_log[0] : 32'hx, 32'h00BB00AA);
      chk("g02 s1", out_log.size() > 1 ? out_log[1] : 32'hx, 32'h00DD00CC);

      // three groups, samples straddle words
      set_cfg(4'b0001);
      in_q.push_back(32'h44332211);
      in_q.push_back(32'h88776655);
      in_q.push_back(32'hCCBBAA99);
      step(1, 1, 0);
      step(1, 0, 0);
      repeat (6) step(1, 1, 0);
      chk("g123 max fill", max_fill, 8);
      chk("g123 s0", out_log.size() > 0 ? out_log[0] : 32'hx, 32'h33221100);
      chk("g123 s1", out_log.size() > 1 ? out_log[1] : 32'hx, 32'h66554400);
      chk("g123 s2", out_log.size() > 2 ? out_log[2] : 32'hx, 32'h99887700);
      chk("g123 s3", out_log.size() > 3 ? out_log[3] : 32'hx, 32'hCCBBAA00);

      // single group with downstream stall
      set_cfg(4'b0111);
      in_q.push_back(32'h04030201);
      in_q.push_back(32'h08070605);
      step(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("stall hold", sto_data, 32'h01000000);
         step(1, 0, 0);
      end
      chk("stall fill", mq.size(), 8);
      chk("stall sti_ready", {31'b0, sti_ready}, 32'd0);
      repeat (9) step(0, 1, 0);
      chk("g3 s0", out_log.size() > 0 ? out_log[0] : 32'hx, 32'h01000000);
      chk("g3 s1", out_log.size() > 1 ? out_log[1] : 32'hx, 32'h02000000);
      chk("g3 s2", out_log.size() > 2 ? out_log[2] : 32'hx, 32'h03000000);
      chk("g3 s3", out_log.size() > 3 ? out_log[3] : 32'hx, 32'h04000000);

      // clr with a partial residual
      set_cfg(4'b0001);
      in_q.push_back(32'h44332211);
      step(1, 0, 0);
      step(0, 1, 0);
      chk("resid fill", mq.size(), 1);
      disabledGroups = 4'b0000;
      step(0, 0, 1);
      chk("clr sto_valid", {31'b0, sto_valid}, 32'd0);
`ifdef DATA_UNALIGN_RESIDUAL_EN
      chk("err set", {31'b0, err_residual}, 32'd1);
`endif
      in_q.push_back(32'hA1B2C3D4);
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("after clr", out_log.size() > 1 ? out_log[1] : 32'hx, 32'hA1B2C3D4);
`ifdef DATA_UNALIGN_RESIDUAL_EN
      chk("err sticky", {31'b0, err_residual}, 32'd1);
`endif

      // asynchronous reset with fill=5
      set_cfg(4'b0111);
      in_q.push_back(32'h14131211);
      in_q.push_back(32'h18171615);
      step(1, 0, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      chk("pre-rst fill", mq.size(), 5);
      rst = 1'b1;
      #1;
      chk("async sto_valid", {31'b0, sto_valid}, 32'd0);
      chk("async sti_ready", {31'b0, sti_ready}, 32'd1);
      do_reset(4'b0000);
      in_q.push_back(32'hCAFEF00D);
      repeat (3) step(1, 1, 0);
      chk("restart", out_log.size() > 0 ? out_log[0] : 32'hx, 32'hCAFEF00D);

      // randomized traffic across configurations
      for (int r = 0; r < 10; r++) begin
         set_cfg(r == 0 ? 4'hf : 4'($urandom));
         for (int i = 0; i < 400; i++) begin
            bit c;
            while (in_q.size() < 2) in_q.push_back($urandom);
            c = ($urandom_range(0, 99) == 0);
            if (c) disabledGroups = 4'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, c);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
